// File: rtl/bound_flasher_pkg.sv
// Shared state encoding and helpers for the bound flasher.
// Optional blink tail is enabled by BOUND_FLASHER_BLINK_EN.
package bound_flasher_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_INIT   = 3'd0,
      ST_ON_B0  = 3'd1,
      ST_OFF_0A = 3'd2,
      ST_ON_B1  = 3'd3,
      ST_OFF_B0 = 3'd4,
      ST_ON_MAX = 3'd5,
      ST_OFF_0B = 3'd6,
      ST_BLINK  = 3'd7
   } state_e;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bound_flasher_blink_timer.sv
// Half-period and pulse counters for the end-of-cycle blink.
// Only instantiated when BOUND_FLASHER_BLINK_EN is defined.
module bound_flasher_blink_timer
   import bound_flasher_pkg::*;
#(
   parameter int BLINK_HALF = 2,
   parameter int BLINK_NUM  = 3
)(
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   output logic o_phase_on,
   output logic o_done
);

   localparam int HW = cnt_w(BLINK_HALF);
   localparam int PW = cnt_w(BLINK_NUM);

   logic [HW-1:0] r_half;
   logic          r_off;
   logic [PW-1:0] r_pulse;
   logic          w_half_end;

   assign w_half_end = (r_half == HW'(BLINK_HALF - 1));

   // Counters idle at zero so every blink starts on an all-on half.
   always_ff @(posedge clk) begin
      if (rst || !i_en) begin
         r_half  <= '0;
         r_off   <= 1'b0;
         r_pulse <= '0;
      end else if (w_half_end) begin
         r_half <= '0;
         r_off  <= ~r_off;
         if (r_off) r_pulse <= r_pulse + PW'(1);
      end else begin
         r_half <= r_half + HW'(1);
      end
   end

   assign o_phase_on = ~r_off;
   assign o_done     = r_off & w_half_end &
                       (r_pulse == PW'(BLINK_NUM - 1));

endmodule

// File: rtl/bound_flasher_lamp_ctrl.sv
// Next-state and thermometer lamp datapath of the bound flasher.
// Define BOUND_FLASHER_BLINK_EN to add the end-of-cycle blink state.
module bound_flasher_lamp_ctrl
   import bound_flasher_pkg::*;
#(
   parameter int LAMP_W = 16,
   parameter int BOUND0 = 5,
   parameter int BOUND1 = 10
`ifdef BOUND_FLASHER_BLINK_EN
   ,
   parameter int BLINK_HALF = 2,
   parameter int BLINK_NUM  = 3
`endif
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                flick,
   input  logic [STATE_W-1:0]  main_state,
   output logic [STATE_W-1:0]  main_state_n,
   output logic [LAMP_W-1:0]   lamp
);

   logic [LAMP_W-1:0] r_lamp;
   logic [LAMP_W-1:0] w_lamp_n;
   logic [LAMP_W-1:0] w_on;
   logic [LAMP_W-1:0] w_off;
   logic              w_kick0;
   logic              w_kick1;
   state_e            w_ns;

   assign w_on  = {r_lamp[LAMP_W-2:0], 1'b1};
   assign w_off = {1'b0, r_lamp[LAMP_W-1:1]};

   // True in the cycle whose ON step would light the bound lamp.
   assign w_kick0 = flick & ~r_lamp[BOUND0] & r_lamp[BOUND0-1];
   assign w_kick1 = flick & ~r_lamp[BOUND1] & r_lamp[BOUND1-1];

`ifdef BOUND_FLASHER_BLINK_EN
   logic w_blink_on;
   logic w_blink_done;

   bound_flasher_blink_timer #(
      .BLINK_HALF (BLINK_HALF),
      .BLINK_NUM  (BLINK_NUM)
   ) u_blink (
      .clk        (clk),
      .rst        (rst),
      .i_en       (main_state == ST_BLINK),
      .o_phase_on (w_blink_on),
      .o_done     (w_blink_done)
   );
`endif

   always_comb begin
      w_ns     = ST_INIT;
      w_lamp_n = '0;
      case (main_state)
         ST_INIT: begin
            w_ns = flick ? ST_ON_B0 : ST_INIT;
         end
         ST_ON_B0: begin
            w_lamp_n = w_on;
            w_ns     = r_lamp[BOUND0-1] ? ST_OFF_0A : ST_ON_B0;
         end
         ST_OFF_0A: begin
            w_lamp_n = w_off;
            w_ns     = r_lamp[1] ? ST_OFF_0A : ST_ON_B1;
         end
         ST_ON_B1: begin
            if (w_kick0) begin
               w_lamp_n = r_lamp;
               w_ns     = ST_OFF_0A;
            end else begin
               w_lamp_n = w_on;
               w_ns     = r_lamp[BOUND1-1] ? ST_OFF_B0 : ST_ON_B1;
            end
         end
         ST_OFF_B0: begin
            w_lamp_n = w_off;
            w_ns     = r_lamp[BOUND0+1] ? ST_OFF_B0 : ST_ON_MAX;
         end
         ST_ON_MAX: begin
            if (w_kick1) begin
               w_lamp_n = r_lamp;
               w_ns     = ST_OFF_B0;
            end else begin
               w_lamp_n = w_on;
               w_ns     = r_lamp[LAMP_W-2] ? ST_OFF_0B : ST_ON_MAX;
            end
         end
         ST_OFF_0B: begin
            w_lamp_n = w_off;
`ifdef BOUND_FLASHER_BLINK_EN
            w_ns     = r_lamp[1] ? ST_OFF_0B : ST_BLINK;
`else
            w_ns     = r_lamp[1] ? ST_OFF_0B : ST_INIT;
`endif
         end
`ifdef BOUND_FLASHER_BLINK_EN
         ST_BLINK: begin
            w_lamp_n = w_blink_on ? '1 : '0;
            w_ns     = w_blink_done ? ST_INIT : ST_BLINK;
         end
`endif
         default: begin
            w_ns     = ST_INIT;
            w_lamp_n = '0;
         end
      endcase
      if (rst) w_ns = ST_INIT;
   end

   always_ff @(posedge clk) begin
      if (rst) r_lamp <= '0;
      else     r_lamp <= w_lamp_n;
   end

   assign main_state_n = w_ns;
   assign lamp         = r_lamp;

endmodule
